// File: rtl/add32_seq_pkg.sv
// Shared ALU definitions for the two-pass 32-bit adder: datapath widths and FSM state encoding.
package add32_seq_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned HalfW = DataW / 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/cla_16_bits.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a second-level
// lookahead unit, so no carry ripples across more than one group.
module cla_16_bits (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [4:0]  gc;

  always_comb begin
    g = a_i & b_i;
    p = a_i ^ b_i;

    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | p[4*j+3] & g[4*j+2]
            | p[4*j+3] & p[4*j+2] & g[4*j+1]
            | p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j];
      pg[j] = &p[4*j +: 4];
    end

    gc[0] = cin_i;
    gc[1] = gg[0] | pg[0] & cin_i;
    gc[2] = gg[1] | pg[1] & gg[0] | pg[1] & pg[0] & cin_i;
    gc[3] = gg[2] | pg[2] & gg[1] | pg[2] & pg[1] & gg[0] | pg[2] & pg[1] & pg[0] & cin_i;
    gc[4] = gg[3] | pg[3] & gg[2] | pg[3] & pg[2] & gg[1] | pg[3] & pg[2] & pg[1] & gg[0]
          | (&pg) & cin_i;

    // Bit carries inside each group are expanded from the group carry-in.
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | p[4*j] & gc[j];
      c[4*j+2] = g[4*j+1] | p[4*j+1] & g[4*j] | p[4*j+1] & p[4*j] & gc[j];
      c[4*j+3] = g[4*j+2] | p[4*j+2] & g[4*j+1] | p[4*j+2] & p[4*j+1] & g[4*j]
               | p[4*j+2] & p[4*j+1] & p[4*j] & gc[j];
    end

    sum_o  = p ^ c;
    cout_o = gc[4];
  end

endmodule

// File: rtl/add32_seq.sv
// 32-bit add/subtract with valid/ready handshakes, computed as two 16-bit passes through a
// single shared carry-lookahead adder (low half, then high half).
module add32_seq
  import add32_seq_pkg::*;
#(
  parameter bit ZERO_EN = 1'b1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DataW-1:0] op_a,
  input  logic [DataW-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DataW-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  state_e             state_q, state_d;
  logic [DataW-1:0]   a_q, a_d;
  logic [DataW-1:0]   b_q, b_d;
  logic               cin_q, cin_d;
  logic [HalfW-1:0]   sum_lo_q, sum_lo_d;
  logic               c16_q, c16_d;
  logic [DataW-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;

  logic [HalfW-1:0]   add_a;
  logic [HalfW-1:0]   add_b;
  logic               add_cin;
  logic [HalfW-1:0]   add_sum;
  logic               add_cout;

  // Half-operand select: the upper halves are only used in the HIGH pass.
  always_comb begin
    if (state_q == StHigh) begin
      add_a   = a_q[DataW-1:HalfW];
      add_b   = b_q[DataW-1:HalfW];
      add_cin = c16_q;
    end else begin
      add_a   = a_q[HalfW-1:0];
      add_b   = b_q[HalfW-1:0];
      add_cin = cin_q;
    end
  end

  cla_16_bits u_cla (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    sum_lo_d   = sum_lo_q;
    c16_d      = c16_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = op_a;
          // Subtraction as A + ~B + 1.
          b_d     = op_b ^ {DataW{sub}};
          cin_d   = sub;
          state_d = StLow;
        end
      end
      StLow: begin
        sum_lo_d = add_sum;
        c16_d    = add_cout;
        state_d  = StHigh;
      end
      StHigh: begin
        result_d   = {add_sum, sum_lo_q};
        carry_d    = add_cout;
        overflow_d = (a_q[DataW-1] == b_q[DataW-1]) && (add_sum[HalfW-1] != a_q[DataW-1]);
        zero_d     = ZERO_EN && ~|{add_sum, sum_lo_q};
        state_d    = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      sum_lo_q   <= '0;
      c16_q      <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      sum_lo_q   <= sum_lo_d;
      c16_q      <= c16_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  // in_ready is gated by clear_n so it drops the moment reset is asserted.
  assign in_ready  = (state_q == StIdle) && clear_n;
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_add32_seq.sv
// Randomized and directed bench for add32_seq against an arithmetic reference model that
// tracks outstanding operations by latency rather than by FSM state.
module tb_add32_seq;

  logic        clock = 1'b0;
  logic        clear_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        carry;
  logic        overflow;
  logic        zero;

  int n_cmp = 0;
  int n_fail = 0;

  add32_seq #(
    .ZERO_EN (1'b1)
  ) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {carry, overflow, zero, result} from plain integer arithmetic.
  function automatic logic [34:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
    logic [32:0] w;
    longint      sa, sb, r;
    logic        c, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      w = {1'b0, a} - {1'b0, b};
      c = (a >= b);
      r = sa - sb;
    end else begin
      w = {1'b0, a} + {1'b0, b};
      c = w[32];
      r = sa + sb;
    end
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {c, ov, (w[31:0] == 32'd0), w[31:0]};
  endfunction

  // Behavioural model: an accepted op produces its answer two edges later and is retired
  // by the first edge that sees out_ready while the answer is presented.
  bit          m_busy = 1'b0;
  int          m_age = 0;
  logic [31:0] m_a, m_b;
  logic        m_s;
  logic [31:0] e_res = '0;
  logic        e_c = 1'b0, e_ov = 1'b0, e_z = 1'b0;

  initial begin
    logic [34:0] r;
    forever begin
      @(posedge clock);
      if (!clear_n) begin
        m_busy = 1'b0;
        m_age  = 0;
        e_res  = '0;
        e_c    = 1'b0;
        e_ov   = 1'b0;
        e_z    = 1'b0;
      end else if (m_busy) begin
        if (m_age >= 2) begin
          if (out_ready) m_busy = 1'b0;
        end else begin
          m_age++;
          if (m_age == 2) begin
            r     = ref_op(m_a, m_b, m_s);
            e_res = r[31:0];
            e_z   = r[32];
            e_ov  = r[33];
            e_c   = r[34];
          end
        end
      end else if (in_valid) begin
        m_a    = op_a;
        m_b    = op_b;
        m_s    = sub;
        m_busy = 1'b1;
        m_age  = 0;
      end
    end
  end

  // Every-cycle compare, 2 time units after the active edge.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_busy && m_age >= 2});
      chk("in_ready", {31'd0, in_ready}, {31'd0, clear_n && !m_busy});
      chk("result", result, e_res);
      chk("carry", {31'd0, carry}, {31'd0, e_c});
      chk("overflow", {31'd0, overflow}, {31'd0, e_ov});
      chk("zero", {31'd0, zero}, {31'd0, e_z});
    end
  end

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int hold, input logic [31:0] er, input logic ec,
                        input logic eov, input logic ez);
    int n;
    int lat;
    @(negedge clock);
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    sub       = s;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    // Garbage on the inputs while busy must be ignored.
    in_valid = 1'b1;
    op_a     = $urandom;
    op_b     = $urandom;
    sub      = 1'($urandom_range(0, 1));
    lat = 1;
    #1;
    while (!out_valid && lat < 10) begin
      @(posedge clock);
      #1;
      if (!out_valid) lat++;
    end
    in_valid = 1'b0;
    chk({name, "_latency"}, lat, 32'd2);
    chk({name, "_result"}, result, er);
    chk({name, "_carry"}, {31'd0, carry}, {31'd0, ec});
    chk({name, "_overflow"}, {31'd0, overflow}, {31'd0, eov});
    chk({name, "_zero"}, {31'd0, zero}, {31'd0, ez});
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({name, "_hold_result"}, result, er);
      chk({name, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk({name, "_retire_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_retire_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [34:0] r;
    #1;
    clear_n = 1'b0;
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_result", result, 32'd0);

    // Pin the reference model against hand-computed answers.
    r = ref_op(32'hFFFF_FFFF, 32'h1, 1'b0);
    chk("model_wrap", {29'd0, r[34:32]}, 32'b101);
    r = ref_op(32'd3, 32'd5, 1'b1);
    chk("model_sub_res", r[31:0], 32'hFFFF_FFFE);
    chk("model_sub_flags", {29'd0, r[34:32]}, 32'b000);
    r = ref_op(32'h7FFF_FFFF, 32'h1, 1'b0);
    chk("model_ovf", {29'd0, r[34:32]}, 32'b010);

    @(negedge clock);
    clear_n = 1'b1;

    run_op("half_carry", 32'h0000_FFFF, 32'h1, 1'b0, 0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    run_op("signed_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_eq", 32'd5, 32'd5, 1'b1, 0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_neg", 32'd3, 32'd5, 1'b1, 3, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

    // Reset while the high half is being computed.
    @(negedge clock);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op_a      = 32'd10;
    op_b      = 32'd20;
    sub       = 1'b0;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    clear_n = 1'b0;
    #1;
    chk("rst_high_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_high_result", result, 32'd0);
    chk("rst_high_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    clear_n = 1'b1;
    run_op("after_rst", 32'd1, 32'd2, 1'b0, 0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);

    // Randomized traffic, backpressure and occasional resets; the compare process checks.
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      clear_n   = ($urandom_range(0, 79) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      op_a      = pick();
      op_b      = pick();
      sub       = 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    clear_n  = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/add32_seq.md
ADD32_SEQ -- requirements
Module: add32_seq

Interface
REQ-001 The block SHALL have one parameter: ZERO_EN, default 1, enables the zero flag (0 ties zero to 0).
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port clear_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the requester presents an operation.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-006 The block SHALL have port op_a, input, 32 bits: operand A.
REQ-007 The block SHALL have port op_b, input, 32 bits: operand B.
REQ-008 The block SHALL have port sub, input, 1 bit: 0 computes A+B, 1 computes A-B.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result and flags are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port result, output, 32 bits: the sum or difference.
REQ-012 The block SHALL have port carry, output, 1 bit: carry out of bit 31 (for sub, 1 = no borrow).
REQ-013 The block SHALL have port overflow, output, 1 bit: signed two's-complement overflow.
REQ-014 The block SHALL have port zero, output, 1 bit: result == 0.

Function
REQ-015 The block SHALL compute the 32-bit result through one shared 16-bit carry-lookahead adder, used over two consecutive cycles.
REQ-016 The FSM SHALL have four states: IDLE, LOW, HIGH and DONE.
REQ-017 The FSM SHALL assert in_ready only in IDLE.
REQ-018 An accept SHALL be the event in_valid && in_ready at a rising edge.
REQ-019 On accept, the block SHALL latch op_a into a_r, latch op_b XOR {32{sub}} into b_r, latch cin_r = sub, and move to LOW.
REQ-020 In LOW, the adder SHALL take a_r[15:0], b_r[15:0] and cin_r; at the edge the block SHALL register sum_lo and c16, and move to HIGH.
REQ-021 In HIGH, the adder SHALL take a_r[31:16], b_r[31:16] and c16; at the edge the block SHALL register result = {sum_hi, sum_lo} and carry.
REQ-022 At the same HIGH edge, the block SHALL register overflow = (a_r[31] == b_r[31]) && (sum_hi[15] != a_r[31]).
REQ-023 At the same HIGH edge, the block SHALL register zero = ~|{sum_hi, sum_lo}, and then move to DONE.
REQ-024 out_valid SHALL be 1 exactly in DONE.
REQ-025 result and all flags SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-026 DONE SHALL move to IDLE at the edge where out_ready = 1.
REQ-027 Latency: for an accept at edge k, out_valid SHALL be first high after edge k+2.
REQ-028 Minimum initiation interval SHALL be 4 cycles (IDLE, LOW, HIGH, DONE with out_ready = 1).
REQ-029 in_valid, op_a, op_b and sub SHALL be ignored in every state except IDLE.
REQ-030 result, carry, overflow and zero SHALL change only at the HIGH->DONE edge or on reset.
REQ-031 All arithmetic SHALL be modulo 2^32; there SHALL be no saturation.

Reset
REQ-032 While clear_n = 0, the block SHALL immediately force state = IDLE, out_valid = 0, result = 0, carry = 0, overflow = 0 and zero = 0.
REQ-033 While clear_n = 0, in_ready SHALL be held at 0.
REQ-034 While clear_n = 0, a_r, b_r, cin_r, sum_lo and c16 SHALL be cleared to 0.
REQ-035 A reset asserted in LOW, HIGH or DONE SHALL discard the operation with no output.
REQ-036 The first accept after reset SHALL be possible on the first rising edge with clear_n = 1.

Structure
REQ-037 The state encodings (IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3) and DATA_W = 32 SHALL reside in a shared ALU definitions include file.
REQ-038 The block SHALL contain exactly one instance of the existing cla_16_bits module, fed by a state-selected half-operand multiplexer.

Verification
REQ-039 Inter-half carry: A = 0x0000FFFF + B = 0x00000001 (sub = 0) SHALL give result = 0x00010000 with carry = 0, overflow = 0, zero = 0, and out_valid high after edge k+2.
REQ-040 Signed overflow: A = 0x7FFFFFFF + B = 0x00000001 SHALL give result = 0x80000000 with overflow = 1 and carry = 0.
REQ-041 Wrap: A = 0xFFFFFFFF + B = 0x00000001 SHALL give result = 0x00000000 with carry = 1, zero = 1 and overflow = 0.
REQ-042 Subtract: 5 - 5 SHALL give 0x00000000 with carry = 1 and zero = 1; 3 - 5 SHALL give 0xFFFFFFFE with carry = 0 and overflow = 0.
REQ-043 Backpressure: out_ready held 0 for 3 cycles in DONE SHALL keep result stable and in_ready = 0, with return to IDLE only at the out_ready = 1 edge.
REQ-044 Reset in HIGH: clear_n pulsed low SHALL give out_valid = 0 and result = 0 immediately, and a following accept of 1 + 2 SHALL give 0x00000003.
